image_stream_proc: RTL and testbench
====================================

# image_stream_proc

Parametrised frame source and point-operation engine for the image-processing pipeline. It holds one RGB888 frame in on-chip memory loaded through a write port. On a start pulse it streams the frame in raster order, PPC pixels per beat, framed by VSYNC/HSYNC. A runtime-selected point operation is applied: pass, brightness add/sub, inverted grey, or threshold. A ready/valid handshake lets downstream sinks apply backpressure.

## Interface
Parameters:
- WIDTH, 640: pixels per row; must be a multiple of PPC.
- HEIGHT, 480: rows per frame.
- PPC, 2: pixels per beat; legal values 1, 2, 4.
- STARTUP_DELAY, 100: VSYNC high duration in cycles (≥1).
- HSYNC_DELAY, 160: blanking cycles before each row (≥1).

Ports:
- HCLK  in  1  clock; all logic on rising edge.
- HRESET  in  1  asynchronous, active-low reset.
- wr_en  in  1  pixel memory write strobe.
- wr_addr  in  clog2(WIDTH*HEIGHT)  raster pixel index; row 0 is the top row.
- wr_data  in  24  pixel {R,G,B}.
- start  in  1  frame request; sampled in IDLE only.
- mode  in  3  0 pass, 1 add, 2 sub, 3 invert-grey, 4 threshold, 5–7 pass.
- bri_value  in  8  brightness offset.
- thr_value  in  8  threshold level.
- busy  out  1  high in any state except IDLE.
- VSYNC  out  1  high during the startup period.
- HSYNC  out  1  equals out_valid (line-active indication).
- out_valid  out  1  beat available.
- out_ready  in  1  sink accepts the beat.
- DATA_R, DATA_G, DATA_B  out  8*PPC each  pixel k in bits [8k+7:8k]; k=0 is the leftmost pixel.
- ctrl_done  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- FSM states: IDLE, VSYNC, HSYNC, DATA.
  - IDLE→VSYNC when start=1.
  - VSYNC→HSYNC after STARTUP_DELAY cycles.
  - HSYNC→DATA after HSYNC_DELAY cycles.
  - DATA→HSYNC after the last beat of a row is accepted; DATA→IDLE after the last beat of the frame is accepted.
- mode, bri_value and thr_value are latched on the accepted start and stay fixed for the whole frame.
- Writes are accepted only in IDLE; wr_en while busy is ignored.
- start while busy is ignored.
- Per-pixel arithmetic on 10-bit intermediates:
  - add: min(c+bri,255).
  - sub: max(c−bri,0).
  - grey g = floor((R+G+B)/3).
  - invert: all channels = 255−g.
  - threshold: all channels = 255 if g>thr_value, else 0 (strictly greater).
- Column counter steps by PPC. Row counter increments when the column wraps. Both counters clear on entry to VSYNC.

## Timing
- Reset values: every output is 0 and the FSM is in IDLE. Memory contents are unaffected by reset.
- Reset asserted mid-frame aborts immediately; no ctrl_done is produced.
- VSYNC is high for exactly STARTUP_DELAY cycles, starting the cycle after start is sampled.
- Each row is preceded by HSYNC_DELAY cycles with out_valid=0.
- Latency: one registered stage. out_valid rises on the cycle after DATA is entered.
- Stall rule: while out_valid=1 and out_ready=0, DATA and out_valid hold stable, and the address and counters freeze.
- A beat transfers when out_valid and out_ready are both 1 on a rising edge.
- With out_ready held at 1, a row takes WIDTH/PPC consecutive beats.
- ctrl_done is high in the cycle after the final handshake, and busy falls in the same cycle.
- start may be accepted on the cycle after ctrl_done.
- out_valid drops to 0 between rows and after the frame ends; DATA is 0 whenever out_valid=0.

## Structure
- Package image_proc_pkg holds:
  - mode encodings (MODE_PASS, MODE_ADD, MODE_SUB, MODE_INV, MODE_THR);
  - FSM state typedef;
  - saturating add/sub and grey functions.
- Sub-module pixel_op is combinational, one pixel per instance (mode, bri, thr, RGB in → RGB out). It is instantiated PPC times.
- Memory is inferred as a WIDTH*HEIGHT×24 array with one write port and PPC read lanes.

## Test plan
- WIDTH=4, HEIGHT=2, PPC=2, delays 3/2, mode 0, pixel i = {i,i+16,i+32}, out_ready=1:
  - VSYNC high for 3 cycles, then 2 blank cycles;
  - beats {R:1,0}, {R:3,2}, blank 2, {R:5,4}, {R:7,6};
  - ctrl_done pulses once.
- Mode 1, bri=100, pixel R=200,G=100,B=0 → 255,200,100. Mode 2, same pixel → 100,0,0.
- Mode 4, thr=90:
  - pixel (91,91,91) → 255;
  - pixel (90,90,91), grey 90 → 0.
  - Mode 3 with pixel (30,60,90) → 195 on all channels.
- out_ready toggled 1,0,0,1: DATA and out_valid hold through both low cycles. No beat is lost or duplicated, checked with a scoreboard against 4 beats.
- HRESET asserted during the second row: all outputs 0 within the same cycle, busy=0. A subsequent start streams the full frame again from pixel 0.
- start and wr_en asserted while busy: no restart, memory unchanged. Mode changed mid-frame: no effect until the next frame.

Source files
------------

// File: rtl/image_stream_proc_pkg.sv
// Shared types and pixel arithmetic for the image stream engine.
// Mode codes, FSM states and saturating helpers.
package image_proc_pkg;

   localparam logic [2:0] MODE_PASS = 3'd0;
   localparam logic [2:0] MODE_ADD  = 3'd1;
   localparam logic [2:0] MODE_SUB  = 3'd2;
   localparam logic [2:0] MODE_INV  = 3'd3;
   localparam logic [2:0] MODE_THR  = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_VSYNC,
      ST_HSYNC,
      ST_DATA
   } state_e;

   function automatic logic [7:0] sat_add(
      input logic [7:0] a,
      input logic [7:0] b
   );
      logic [9:0] s;
      s = {2'b00, a} + {2'b00, b};
      return (s > 10'd255) ? 8'hff : 8'(s);
   endfunction

   function automatic logic [7:0] sat_sub(
      input logic [7:0] a,
      input logic [7:0] b
   );
      logic [9:0] s;
      s = {2'b00, a} - {2'b00, b};
      return s[9] ? 8'h00 : 8'(s);
   endfunction

   function automatic logic [7:0] grey(
      input logic [7:0] r,
      input logic [7:0] g,
      input logic [7:0] b
   );
      logic [9:0] s;
      s = {2'b00, r} + {2'b00, g} + {2'b00, b};
      return 8'(s / 10'd3);
   endfunction

endpackage

// File: rtl/image_stream_proc_if.sv
// Pixel beat stream: valid/ready plus PPC-wide colour planes.
// The master drives beats, the slave applies backpressure.
interface image_stream_if #(
   parameter int PPC = 2
) ();

   logic               out_valid;
   logic               out_ready;
   logic [8*PPC-1:0]   DATA_R;
   logic [8*PPC-1:0]   DATA_G;
   logic [8*PPC-1:0]   DATA_B;

   modport master (
      output out_valid,
      output DATA_R,
      output DATA_G,
      output DATA_B,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  DATA_R,
      input  DATA_G,
      input  DATA_B,
      output out_ready
   );

endinterface

// File: rtl/image_stream_proc_pixel_op.sv
// Combinational point operation on one RGB888 pixel.
// Modes 5-7 fall through to pass.
module pixel_op
   import image_proc_pkg::*;
(
   input  logic [2:0]  mode,
   input  logic [7:0]  bri,
   input  logic [7:0]  thr,
   input  logic [23:0] pix,
   output logic [23:0] res
);

   logic [7:0] r, g, b;
   logic [7:0] grey_v, inv_v, thr_v;

   assign r      = pix[23:16];
   assign g      = pix[15:8];
   assign b      = pix[7:0];
   assign grey_v = grey(r, g, b);
   assign inv_v  = 8'hff - grey_v;
   assign thr_v  = (grey_v > thr) ? 8'hff : 8'h00;

   always_comb begin
      res = pix;
      unique case (1'b1)
         (mode == MODE_ADD):
            res = {sat_add(r, bri), sat_add(g, bri), sat_add(b, bri)};
         (mode == MODE_SUB):
            res = {sat_sub(r, bri), sat_sub(g, bri), sat_sub(b, bri)};
         (mode == MODE_INV):
            res = {inv_v, inv_v, inv_v};
         (mode == MODE_THR):
            res = {thr_v, thr_v, thr_v};
         default:
            res = pix;
      endcase
   end

endmodule

// File: rtl/image_stream_proc.sv
// Frame buffer and point-op streamer with VSYNC/HSYNC framing.
// One output register stage; beats stall in place under backpressure.
module image_stream_proc
   import image_proc_pkg::*;
#(
   parameter int WIDTH         = 640,
   parameter int HEIGHT        = 480,
   parameter int PPC           = 2,
   parameter int STARTUP_DELAY = 100,
   parameter int HSYNC_DELAY   = 160,
   localparam int AW           = $clog2(WIDTH*HEIGHT)
) (
   input  logic          HCLK,
   input  logic          HRESET,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [23:0]   wr_data,
   input  logic          start,
   input  logic [2:0]    mode,
   input  logic [7:0]    bri_value,
   input  logic [7:0]    thr_value,
   output logic          busy,
   output logic          VSYNC,
   output logic          HSYNC,
   output logic          ctrl_done,
   image_stream_if.master st
);

   localparam int N  = WIDTH * HEIGHT;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   state_e            state, state_n;
   logic [15:0]       cnt;
   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic [AW-1:0]     addr;
   logic              row_iss;
   logic              vld_q;
   logic              done_q;
   logic [2:0]        mode_q;
   logic [7:0]        bri_q;
   logic [7:0]        thr_q;
   logic [8*PPC-1:0]  r_q, g_q, b_q;
   logic [8*PPC-1:0]  op_r, op_g, op_b;
   logic [23:0]       mem [N];
   logic              load, xfer;
   logic              col_last, row_last, row_end;

   // row_iss marks that the row's last beat sits in the output register
   assign xfer     = vld_q & st.out_ready;
   assign load     = (state == ST_DATA) & ~row_iss
                   & (~vld_q | st.out_ready);
   assign col_last = (col == CW'(WIDTH - PPC));
   assign row_last = (row == RW'(HEIGHT - 1));
   assign row_end  = (state == ST_DATA) & row_iss & xfer;

   always_comb begin
      state_n = state;
      unique case (state)
         ST_IDLE:
            if (start) state_n = ST_VSYNC;
         ST_VSYNC:
            if (cnt == 16'(STARTUP_DELAY - 1)) state_n = ST_HSYNC;
         ST_HSYNC:
            if (cnt == 16'(HSYNC_DELAY - 1)) state_n = ST_DATA;
         ST_DATA:
            if (row_end) state_n = row_last ? ST_IDLE : ST_HSYNC;
         default:
            state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESET) begin
      if (!HRESET) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         col     <= '0;
         row     <= '0;
         addr    <= '0;
         row_iss <= 1'b0;
         vld_q   <= 1'b0;
         done_q  <= 1'b0;
         mode_q  <= '0;
         bri_q   <= '0;
         thr_q   <= '0;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
      end else begin
         state  <= state_n;
         done_q <= row_end & row_last;
         if (state == ST_IDLE && start) begin
            mode_q  <= mode;
            bri_q   <= bri_value;
            thr_q   <= thr_value;
            cnt     <= '0;
            col     <= '0;
            row     <= '0;
            addr    <= '0;
            row_iss <= 1'b0;
         end
         if (state == ST_VSYNC || state == ST_HSYNC)
            cnt <= (state_n != state) ? '0 : cnt + 16'd1;
         if (load) begin
            col     <= col_last ? '0 : col + CW'(PPC);
            addr    <= addr + AW'(PPC);
            row_iss <= col_last;
         end
         if (row_end) begin
            row_iss <= 1'b0;
            row     <= row + RW'(1);
            cnt     <= '0;
         end
         if (load) begin
            vld_q <= 1'b1;
            r_q   <= op_r;
            g_q   <= op_g;
            b_q   <= op_b;
         end else if (xfer) begin
            vld_q <= 1'b0;
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
         end
      end
   end

   // frame store survives reset
   always_ff @(posedge HCLK) begin
      if (wr_en && state == ST_IDLE)
         mem[wr_addr] <= wr_data;
   end

   for (genvar k = 0; k < PPC; k++) begin : g_lane
      logic [23:0] px;
      logic [23:0] res;
      assign px = mem[addr + AW'(k)];
      pixel_op u_op (
         .mode (mode_q),
         .bri  (bri_q),
         .thr  (thr_q),
         .pix  (px),
         .res  (res)
      );
      assign op_r[8*k +: 8] = res[23:16];
      assign op_g[8*k +: 8] = res[15:8];
      assign op_b[8*k +: 8] = res[7:0];
   end

   assign busy         = (state != ST_IDLE);
   assign VSYNC        = (state == ST_VSYNC);
   assign HSYNC        = vld_q;
   assign ctrl_done    = done_q;
   assign st.out_valid = vld_q;
   assign st.DATA_R    = r_q;
   assign st.DATA_G    = g_q;
   assign st.DATA_B    = b_q;

endmodule

// File: tb/tb_image_stream_proc.sv
// Directed bench for image_stream_proc on a 4x2 frame, 2 pixels/beat.
// Each task drives one scenario and checks against hand-derived values.
module tb_image_stream_proc;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int P  = 2;
   localparam int SD = 3;
   localparam int HD = 2;
   localparam int AW = $clog2(W*H);

   localparam logic [47:0] EXP_PASS [4] = '{
      48'h0100_1110_2120, 48'h0302_1312_2322,
      48'h0504_1514_2524, 48'h0706_1716_2726
   };

   logic          HCLK = 1'b0;
   logic          HRESET = 1'b0;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [23:0]   wr_data;
   logic          start;
   logic [2:0]    mode;
   logic [7:0]    bri_value;
   logic [7:0]    thr_value;
   logic          busy, VSYNC, HSYNC, ctrl_done;

   image_stream_if #(.PPC(P)) st ();

   image_stream_proc #(
      .WIDTH(W), .HEIGHT(H), .PPC(P),
      .STARTUP_DELAY(SD), .HSYNC_DELAY(HD)
   ) dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .start     (start),
      .mode      (mode),
      .bri_value (bri_value),
      .thr_value (thr_value),
      .busy      (busy),
      .VSYNC     (VSYNC),
      .HSYNC     (HSYNC),
      .ctrl_done (ctrl_done),
      .st        (st)
   );

   always #5 HCLK = ~HCLK;

   int checks = 0;
   int failures = 0;

   logic [47:0] beats[$];
   int          bcyc[$];
   int vs_cnt, vs_first, done_cnt, done_cyc, busy_at_done;
   int hs_err, zero_err, hold_err, hold_n;
   int inj_cyc = -1;
   logic [23:0] fr [W*H];
   logic        rdy_pat [64];

   function automatic logic [47:0] beat(input int j);
      if (j < beats.size()) return beats[j];
      return 'x;
   endfunction

   function automatic int bc(input int j);
      if (j < bcyc.size()) return bcyc[j];
      return -1;
   endfunction

   function automatic logic [7:0] px(input int ch, input int i);
      logic [47:0] w;
      w = beat(i / 2);
      return w[(2-ch)*16 + 8*(i%2) +: 8];
   endfunction

   task automatic load_frame();
      for (int i = 0; i < W*H; i++) begin
         @(negedge HCLK);
         wr_en = 1'b1; wr_addr = AW'(i); wr_data = fr[i];
      end
      @(negedge HCLK);
      wr_en = 1'b0;
   endtask

   task automatic load_ramp();
      for (int i = 0; i < W*H; i++)
         fr[i] = {8'(i), 8'(i + 16), 8'(i + 32)};
      load_frame();
   endtask

   // caller is at a negedge; returns at the negedge of frame cycle 0
   task automatic go(input logic [2:0] m, input logic [7:0] b,
                     input logic [7:0] t);
      start = 1'b1; mode = m; bri_value = b; thr_value = t;
      @(negedge HCLK);
      start = 1'b0; mode = 3'd2; bri_value = 8'd7; thr_value = 8'd255;
   endtask

   task automatic capture(input int maxc, input bit stop_now);
      logic        pv, pr;
      logic [47:0] pd, cur;
      beats.delete(); bcyc.delete();
      vs_cnt = 0; vs_first = -1; done_cnt = 0; done_cyc = -1;
      busy_at_done = -1; hs_err = 0; zero_err = 0;
      hold_err = 0; hold_n = 0;
      pv = 1'b0; pr = 1'b1; pd = '0;
      for (int c = 0; c < maxc; c++) begin
         st.out_ready = rdy_pat[c];
         if (c == inj_cyc) begin
            start = 1'b1; mode = 3'd3; wr_en = 1'b1;
            wr_addr = '0; wr_data = 24'habcdef;
         end else begin
            start = 1'b0; wr_en = 1'b0;
         end
         cur = {st.DATA_R, st.DATA_G, st.DATA_B};
         if (VSYNC) begin
            vs_cnt++;
            if (vs_first < 0) vs_first = c;
         end
         if (HSYNC !== st.out_valid) hs_err++;
         if (!st.out_valid && cur !== 48'h0) zero_err++;
         if (pv && !pr) begin
            hold_n++;
            if (st.out_valid !== 1'b1 || cur !== pd) hold_err++;
         end
         if (st.out_valid && st.out_ready) begin
            beats.push_back(cur); bcyc.push_back(c);
         end
         pv = st.out_valid; pr = st.out_ready; pd = cur;
         if (ctrl_done) begin
            done_cnt++;
            if (done_cyc < 0) begin done_cyc = c; busy_at_done = busy; end
            if (stop_now) break;
         end
         if (done_cyc >= 0 && c >= done_cyc + 2) break;
         @(negedge HCLK);
      end
      start = 1'b0; wr_en = 1'b0; st.out_ready = 1'b1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge HCLK);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (VSYNC !== 1'b0) begin failures++; $display("FAIL rst_vsync got=%b exp=0", VSYNC); end
      checks++; if (st.out_valid !== 1'b0 || HSYNC !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b/%b exp=0", st.out_valid, HSYNC); end
      checks++; if ({st.DATA_R, st.DATA_G, st.DATA_B} !== 48'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", {st.DATA_R, st.DATA_G, st.DATA_B}); end
      checks++; if (ctrl_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", ctrl_done); end
      HRESET = 1'b1;
      @(negedge HCLK);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_frame_pass();
      load_ramp();
      go(3'd0, 8'd0, 8'd0);
      capture(40, 1'b0);
      checks++; if (vs_first !== 0) begin failures++; $display("FAIL pass_vs_first got=%0d exp=0", vs_first); end
      checks++; if (vs_cnt !== SD) begin failures++; $display("FAIL pass_vs_len got=%0d exp=%0d", vs_cnt, SD); end
      checks++; if (beats.size() !== 4) begin failures++; $display("FAIL pass_nbeats got=%0d exp=4", beats.size()); end
      for (int j = 0; j < 4; j++) begin
         checks++; if (beat(j) !== EXP_PASS[j]) begin failures++; $display("FAIL pass_beat%0d got=%h exp=%h", j, beat(j), EXP_PASS[j]); end
      end
      // HD blank cycles plus one cycle of output-register latency
      checks++; if (bc(0) !== 6 || bc(1) !== 7) begin failures++; $display("FAIL pass_row0_cyc got=%0d,%0d exp=6,7", bc(0), bc(1)); end
      checks++; if (bc(2) !== 11 || bc(3) !== 12) begin failures++; $display("FAIL pass_row1_cyc got=%0d,%0d exp=11,12", bc(2), bc(3)); end
      checks++; if (done_cnt !== 1 || done_cyc !== 13) begin failures++; $display("FAIL pass_done got=%0dx@%0d exp=1x@13", done_cnt, done_cyc); end
      checks++; if (busy_at_done !== 0) begin failures++; $display("FAIL pass_busy_at_done got=%0d exp=0", busy_at_done); end
      checks++; if (hs_err !== 0) begin failures++; $display("FAIL pass_hsync got=%0d exp=0", hs_err); end
      checks++; if (zero_err !== 0) begin failures++; $display("FAIL pass_idle_data got=%0d exp=0", zero_err); end
   endtask

   task automatic test_stall();
      rdy_pat[7] = 1'b0; rdy_pat[8] = 1'b0;
      go(3'd0, 8'd0, 8'd0);
      capture(40, 1'b0);
      rdy_pat[7] = 1'b1; rdy_pat[8] = 1'b1;
      checks++; if (beats.size() !== 4) begin failures++; $display("FAIL stall_nbeats got=%0d exp=4", beats.size()); end
      for (int j = 0; j < 4; j++) begin
         checks++; if (beat(j) !== EXP_PASS[j]) begin failures++; $display("FAIL stall_beat%0d got=%h exp=%h", j, beat(j), EXP_PASS[j]); end
      end
      checks++; if (hold_n !== 2 || hold_err !== 0) begin failures++; $display("FAIL stall_hold got=%0d/%0d exp=2/0", hold_n, hold_err); end
      checks++; if (bc(1) !== 9 || bc(3) !== 14) begin failures++; $display("FAIL stall_cyc got=%0d,%0d exp=9,14", bc(1), bc(3)); end
      checks++; if (done_cnt !== 1 || done_cyc !== 15) begin failures++; $display("FAIL stall_done got=%0dx@%0d exp=1x@15", done_cnt, done_cyc); end
   endtask

   task automatic test_back_to_back();
      go(3'd0, 8'd0, 8'd0);
      capture(40, 1'b1);
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL b2b_first_done got=%0d exp=1", done_cnt); end
      @(negedge HCLK);
      // threshold 20 on ramp: grey(i) = i+16, so pixels 5..7 exceed it
      go(3'd4, 8'd0, 8'd20);
      capture(40, 1'b0);
      checks++; if (vs_first !== 0 || vs_cnt !== SD) begin failures++; $display("FAIL b2b_vsync got=%0d/%0d exp=0/%0d", vs_first, vs_cnt, SD); end
      checks++; if (beat(0) !== 48'h0 || beat(1) !== 48'h0) begin failures++; $display("FAIL b2b_low got=%h,%h exp=0,0", beat(0), beat(1)); end
      checks++; if (beat(2) !== 48'hff00_ff00_ff00) begin failures++; $display("FAIL b2b_beat2 got=%h exp=ff00ff00ff00", beat(2)); end
      checks++; if (beat(3) !== 48'hffff_ffff_ffff) begin failures++; $display("FAIL b2b_beat3 got=%h exp=ffffffffffff", beat(3)); end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL b2b_done got=%0d exp=1", done_cnt); end
   endtask

   task automatic test_busy_ignore();
      inj_cyc = 2;
      go(3'd0, 8'd0, 8'd0);
      capture(40, 1'b0);
      inj_cyc = -1;
      checks++; if (vs_cnt !== SD || bc(0) !== 6) begin failures++; $display("FAIL busy_restart got=%0d/%0d exp=%0d/6", vs_cnt, bc(0), SD); end
      checks++; if (beat(0) !== EXP_PASS[0] || beat(3) !== EXP_PASS[3]) begin failures++; $display("FAIL busy_data got=%h,%h exp=%h,%h", beat(0), beat(3), EXP_PASS[0], EXP_PASS[3]); end
      checks++; if (done_cnt !== 1 || done_cyc !== 13) begin failures++; $display("FAIL busy_done got=%0dx@%0d exp=1x@13", done_cnt, done_cyc); end
      // next frame sees the new mode and the untouched pixel 0
      go(3'd3, 8'd0, 8'd0);
      capture(40, 1'b0);
      checks++; if (px(0, 0) !== 8'd239 || px(2, 0) !== 8'd239) begin failures++; $display("FAIL inv_pix0 got=%0d,%0d exp=239", px(0, 0), px(2, 0)); end
      checks++; if (px(1, 7) !== 8'd232) begin failures++; $display("FAIL inv_pix7 got=%0d exp=232", px(1, 7)); end
   endtask

   task automatic test_reset_mid();
      int dn;
      go(3'd0, 8'd0, 8'd0);
      repeat (11) @(negedge HCLK);
      checks++; if (st.out_valid !== 1'b1 || st.DATA_R !== 16'h0504) begin failures++; $display("FAIL mid_row1 got=%b/%h exp=1/0504", st.out_valid, st.DATA_R); end
      HRESET = 1'b0;
      #1;
      checks++; if ({busy, VSYNC, HSYNC, st.out_valid, ctrl_done} !== 5'b0) begin failures++; $display("FAIL mid_rst_ctl got=%b exp=00000", {busy, VSYNC, HSYNC, st.out_valid, ctrl_done}); end
      checks++; if ({st.DATA_R, st.DATA_G, st.DATA_B} !== 48'h0) begin failures++; $display("FAIL mid_rst_data got=%h exp=0", {st.DATA_R, st.DATA_G, st.DATA_B}); end
      dn = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge HCLK);
         if (ctrl_done) dn++;
      end
      HRESET = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge HCLK);
         if (ctrl_done) dn++;
      end
      checks++; if (dn !== 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", dn); end
      go(3'd0, 8'd0, 8'd0);
      capture(40, 1'b0);
      checks++; if (beats.size() !== 4 || beat(0) !== EXP_PASS[0] || beat(3) !== EXP_PASS[3]) begin failures++; $display("FAIL mid_refetch got=%0d %h %h exp=4 %h %h", beats.size(), beat(0), beat(3), EXP_PASS[0], EXP_PASS[3]); end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL mid_refetch_done got=%0d exp=1", done_cnt); end
   endtask

   task automatic test_arith();
      logic [2:0] tm [5] = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd6};
      logic [7:0] tb [5] = '{8'd100, 8'd100, 8'd0, 8'd0, 8'd0};
      logic [7:0] tt [5] = '{8'd0, 8'd0, 8'd90, 8'd0, 8'd0};
      // {frame, channel, pixel, expected}
      int tab [23][4] = '{
         '{0,0,0,255}, '{0,1,0,200}, '{0,2,0,100}, '{0,0,5,255}, '{0,0,6,110},
         '{1,0,0,100}, '{1,1,0,0},   '{1,2,0,0},   '{1,0,5,155}, '{1,0,6,0},
         '{2,0,1,255}, '{2,1,1,255}, '{2,2,1,255}, '{2,0,2,0},   '{2,2,2,0},
         '{3,0,3,195}, '{3,1,3,195}, '{3,2,3,195}, '{3,0,5,0},   '{3,0,4,255},
         '{4,0,7,128}, '{4,1,7,1},   '{4,2,7,2}
      };
      fr = '{24'hc86400, 24'h5b5b5b, 24'h5a5a5b, 24'h1e3c5a,
             24'h000000, 24'hffffff, 24'h0a141e, 24'h800102};
      load_frame();
      for (int k = 0; k < 5; k++) begin
         go(tm[k], tb[k], tt[k]);
         capture(40, 1'b0);
         checks++; if (beats.size() !== 4) begin failures++; $display("FAIL arith_m%0d_nbeats got=%0d exp=4", tm[k], beats.size()); end
         for (int e = 0; e < 23; e++) begin
            if (tab[e][0] == k) begin
               checks++;
               if (px(tab[e][1], tab[e][2]) !== 8'(tab[e][3])) begin
                  failures++;
                  $display("FAIL arith_m%0d_ch%0d_px%0d got=%0d exp=%0d", tm[k], tab[e][1], tab[e][2], px(tab[e][1], tab[e][2]), tab[e][3]);
               end
            end
         end
      end
   endtask

   initial begin
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
      mode = '0; bri_value = '0; thr_value = '0;
      st.out_ready = 1'b1;
      for (int i = 0; i < 64; i++) rdy_pat[i] = 1'b1;
      test_reset();
      test_frame_pass();
      test_stall();
      test_back_to_back();
      test_busy_ignore();
      test_reset_mid();
      test_arith();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
